// File: rtl/rf_write_scheduler.sv
// rf_write_scheduler: round-robin arbiter of two register-file write requesters into one registered write port.
// Optional busy-bit scoreboard with decode stall, compiled in by defining RF_SCOREBOARD_EN.
module rf_write_scheduler #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wb_valid,
   input  logic [AW-1:0] wb_rd,
   input  logic [DW-1:0] wb_din,
   output logic          wb_ready,
   input  logic          ld_valid,
   input  logic [AW-1:0] ld_rd,
   input  logic [DW-1:0] ld_din,
   output logic          ld_ready,
   output logic          w_rb,
   output logic [AW-1:0] rd,
   output logic [DW-1:0] din,
   input  logic          issue_valid,
   input  logic [AW-1:0] issue_rd,
   input  logic [AW-1:0] rs,
   input  logic [AW-1:0] rt,
   output logic          stall
);
   logic          r_pref_ld;
   logic          w_wb_gnt;
   logic          w_ld_gnt;
   logic          w_xfer;
   logic [AW-1:0] w_rd;
   logic [DW-1:0] w_din;

   // r_pref_ld is set after a wb grant so ld wins the next tie
   assign w_wb_gnt = !rst && wb_valid && (!ld_valid || !r_pref_ld);
   assign w_ld_gnt = !rst && ld_valid && !w_wb_gnt;
   assign wb_ready = w_wb_gnt;
   assign ld_ready = w_ld_gnt;
   assign w_xfer   = w_wb_gnt || w_ld_gnt;
   assign w_rd     = w_wb_gnt ? wb_rd : ld_rd;
   assign w_din    = w_wb_gnt ? wb_din : ld_din;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pref_ld <= 1'b0;
         w_rb      <= 1'b0;
         rd        <= '0;
         din       <= '0;
      end else begin
         w_rb <= w_xfer && (w_rd != '0);
         if (w_xfer) begin
            r_pref_ld <= w_wb_gnt;
            rd        <= w_rd;
            din       <= w_din;
         end
      end
   end

`ifdef RF_SCOREBOARD_EN
   localparam int NR = 2**AW;
   logic [NR-1:0] r_busy;
   logic [NR-1:0] w_set;
   logic [NR-1:0] w_clr;

   // set is applied after clear so a same-edge issue keeps the bit busy
   assign w_set = (issue_valid && issue_rd != '0) ? (NR'(1) << issue_rd) : '0;
   assign w_clr = w_xfer ? (NR'(1) << w_rd) : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_busy <= '0;
      else     r_busy <= (r_busy & ~w_clr) | w_set;
   end

   assign stall = (rs != '0 && r_busy[rs]) || (rt != '0 && r_busy[rt]);
`else
   logic w_unused;
   assign w_unused = ^{issue_valid, issue_rd, rs, rt};
   assign stall    = 1'b0;
`endif
endmodule

// File: tb/tb_rf_write_scheduler.sv
// tb_rf_write_scheduler: directed checks of arbitration, write latency, r0 suppression, scoreboard and async reset.
module tb_rf_write_scheduler;
   localparam int DW = 32;
   localparam int AW = 5;
`ifdef RF_SCOREBOARD_EN
   localparam bit SB = 1'b1;
`else
   localparam bit SB = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          wb_valid, ld_valid, issue_valid;
   logic [AW-1:0] wb_rd, ld_rd, issue_rd, rs, rt;
   logic [DW-1:0] wb_din, ld_din;
   logic          wb_ready, ld_ready, w_rb, stall;
   logic [AW-1:0] rd;
   logic [DW-1:0] din;
   int            tests = 0;
   int            fails = 0;

   rf_write_scheduler #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_din(wb_din), .wb_ready(wb_ready),
      .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_din(ld_din), .ld_ready(ld_ready),
      .w_rb(w_rb), .rd(rd), .din(din),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .rs(rs), .rt(rt), .stall(stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst = 1'b1; wb_valid = 1'b1; ld_valid = 1'b1; issue_valid = 1'b0;
      wb_rd = '0; ld_rd = '0; issue_rd = '0; rs = '0; rt = '0; wb_din = '0; ld_din = '0;
      #2;
      chk("rst_w_rb", w_rb, 0);
      chk("rst_rd", rd, 0);
      chk("rst_din", din, 0);
      chk("rst_stall", stall, 0);
      chk("rst_wb_ready", wb_ready, 0);
      chk("rst_ld_ready", ld_ready, 0);
      wb_valid = 1'b0; ld_valid = 1'b0;
      tick();
      rst = 1'b0;
      // single wb write
      wb_valid = 1'b1; wb_rd = 5'd2; wb_din = 32'h45;
      #1;
      chk("wb_ready_single", wb_ready, 1);
      chk("ld_ready_idle", ld_ready, 0);
      tick();
      wb_valid = 1'b0;
      chk("wb_w_rb", w_rb, 1);
      chk("wb_rd", rd, 2);
      chk("wb_din", din, 32'h45);
      tick();
      chk("idle_w_rb", w_rb, 0);
      chk("idle_rd_hold", rd, 2);
      chk("idle_din_hold", din, 32'h45);
      // fresh reset so the first tie goes to wb
      rst = 1'b1;
      #1;
      rst = 1'b0;
      wb_valid = 1'b1; wb_rd = 5'd3; wb_din = 32'h30;
      ld_valid = 1'b1; ld_rd = 5'd4; ld_din = 32'h40;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("tie%0d_wb_ready", i), wb_ready, (i % 2 == 0) ? 1 : 0);
         chk($sformatf("tie%0d_ld_ready", i), ld_ready, (i % 2 == 0) ? 0 : 1);
         tick();
         chk($sformatf("tie%0d_w_rb", i), w_rb, 1);
         chk($sformatf("tie%0d_rd", i), rd, (i % 2 == 0) ? 3 : 4);
         chk($sformatf("tie%0d_din", i), din, (i % 2 == 0) ? 32'h30 : 32'h40);
      end
      wb_valid = 1'b0; ld_valid = 1'b0;
      tick();
      chk("tie_end_w_rb", w_rb, 0);
      // write to r0 is accepted but suppressed
      ld_valid = 1'b1; ld_rd = 5'd0; ld_din = 32'hFFFF_FFFF;
      #1;
      chk("r0_ld_ready", ld_ready, 1);
      tick();
      ld_valid = 1'b0;
      chk("r0_w_rb", w_rb, 0);
      chk("r0_rd", rd, 0);
      chk("r0_din", din, 32'hFFFF_FFFF);
      // pointer holds across idle cycles after a wb grant
      wb_valid = 1'b1; wb_rd = 5'd6; wb_din = 32'h66;
      tick();
      wb_valid = 1'b0;
      tick();
      tick();
      chk("hold_w_rb", w_rb, 0);
      chk("hold_rd", rd, 6);
      wb_valid = 1'b1; wb_rd = 5'd8; wb_din = 32'h88;
      ld_valid = 1'b1; ld_rd = 5'd10; ld_din = 32'hAA;
      #1;
      chk("hold_tie_wb_ready", wb_ready, 0);
      chk("hold_tie_ld_ready", ld_ready, 1);
      tick();
      wb_valid = 1'b0; ld_valid = 1'b0;
      chk("hold_tie_rd", rd, 10);
      chk("hold_tie_din", din, 32'hAA);
      // scoreboard set, stall, and clear by a load write
      issue_valid = 1'b1; issue_rd = 5'd5;
      tick();
      issue_valid = 1'b0; rs = 5'd5;
      #1;
      chk("sb_stall_rs5", stall, SB ? 1 : 0);
      rs = 5'd0;
      #1;
      chk("sb_rs0_nostall", stall, 0);
      rs = 5'd5;
      ld_valid = 1'b1; ld_rd = 5'd5; ld_din = 32'h55;
      tick();
      ld_valid = 1'b0;
      chk("sb_clear_w_rb", w_rb, 1);
      chk("sb_clear_stall", stall, 0);
      rs = 5'd0;
      issue_valid = 1'b1; issue_rd = 5'd0;
      tick();
      issue_valid = 1'b0;
      chk("sb_r0_never_busy", stall, 0);
      // same-edge set and clear: set wins
      issue_valid = 1'b1; issue_rd = 5'd7;
      ld_valid = 1'b1; ld_rd = 5'd7; ld_din = 32'h77;
      tick();
      issue_valid = 1'b0; ld_valid = 1'b0; rt = 5'd7;
      #1;
      chk("sb_same_w_rb", w_rb, 1);
      chk("sb_same_rd", rd, 7);
      chk("sb_same_stall_rt7", stall, SB ? 1 : 0);
      tick();
      rt = 5'd0;
      // asynchronous reset with a write in flight and busy[9] set
      issue_valid = 1'b1; issue_rd = 5'd9;
      wb_valid = 1'b1; wb_rd = 5'd3; wb_din = 32'h33;
      tick();
      issue_valid = 1'b0; rs = 5'd9;
      #1;
      chk("ar_pre_w_rb", w_rb, 1);
      chk("ar_pre_stall", stall, SB ? 1 : 0);
      rst = 1'b1;
      #1;
      chk("ar_w_rb", w_rb, 0);
      chk("ar_rd", rd, 0);
      chk("ar_din", din, 0);
      chk("ar_stall", stall, 0);
      chk("ar_wb_ready", wb_ready, 0);
      wb_valid = 1'b0; rs = 5'd0;
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_w_rb", w_rb, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
